// File: rtl/lockstep_fixpoint_monitor_pkg.sv
// Shared types for the lockstep fixpoint monitor: verdict codes, controller states
// and the depth counter width helper.
package lockstep_pkg;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    PASS  = 2'd1,
    FAIL  = 2'd2,
    BOUND = 2'd3
  } verdict_e;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RUN     = 3'd1,
    PASS_S  = 3'd2,
    FAIL_S  = 3'd3,
    BOUND_S = 3'd4
  } fsm_e;

  // The depth counter must be able to hold MAX_DEPTH itself.
  function automatic int depth_w(input int max_depth);
    return $clog2(max_depth + 1);
  endfunction

endpackage

// File: rtl/lockstep_fixpoint_monitor_chain_next.sv
// One transition of a set/clear chain: a clear cell may only be set when its
// predecessor is set (cell 0 always sees a set predecessor).
module chain_next #(
  parameter int WIDTH = 9
) (
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] set,
  input  logic [WIDTH-1:0] clr,
  output logic [WIDTH-1:0] next
);

  logic [WIDTH-1:0] prev_s;

  // Predecessor view is taken from the old vector so cells do not ripple.
  always_comb begin
    prev_s = {s[WIDTH-2:0], 1'b1};
  end

  // Per-cell set/clear transition.
  always_comb begin
    next = {WIDTH{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      if (s[i]) begin
        next[i] = ~clr[i];
      end else begin
        next[i] = prev_s[i] & set[i];
      end
    end
  end

endmodule

// File: rtl/lockstep_fixpoint_monitor.sv
// Steps two set/clear chain copies in lockstep and reports divergence of the
// observed cell, a stable fixpoint, or the step bound.
module lockstep_fixpoint_monitor
  import lockstep_pkg::*;
#(
  parameter int WIDTH     = 9,
  parameter int MAX_DEPTH = 16,
  parameter int OBS_BIT   = WIDTH - 1,
  parameter int STABLE    = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           step_valid,
  output logic                           step_ready,
  input  logic [WIDTH-1:0]               set_a,
  input  logic [WIDTH-1:0]               clr_a,
  input  logic [WIDTH-1:0]               set_b,
  input  logic [WIDTH-1:0]               clr_b,
  output logic [WIDTH-1:0]               state_a,
  output logic [WIDTH-1:0]               state_b,
  output logic [depth_w(MAX_DEPTH)-1:0]  depth,
  output logic                           done,
  output logic [1:0]                     verdict
);

  localparam int DW = depth_w(MAX_DEPTH);
  localparam int SW = $clog2(STABLE + 1);

  fsm_e             fsm_r, fsm_n_s;
  verdict_e         verdict_r, verdict_n_s;
  logic [WIDTH-1:0] state_a_r, state_b_r, state_a_n_s, state_b_n_s;
  logic [WIDTH-1:0] next_a_s, next_b_s;
  logic [DW-1:0]    depth_r, depth_n_s, depth_inc_s;
  logic [SW-1:0]    stable_r, stable_n_s, stable_inc_s;
  logic             done_r, step_ready_r;
  logic             unchanged_s, at_bound_s;

  chain_next #(.WIDTH(WIDTH)) u_chain_a (
    .s(state_a_r), .set(set_a), .clr(clr_a), .next(next_a_s)
  );

  chain_next #(.WIDTH(WIDTH)) u_chain_b (
    .s(state_b_r), .set(set_b), .clr(clr_b), .next(next_b_s)
  );

  // Candidate values shared by the step checks.
  always_comb begin
    depth_inc_s  = depth_r + DW'(1);
    stable_inc_s = stable_r + SW'(1);
    unchanged_s  = (next_a_s == state_a_r) && (next_b_s == state_b_r);
    at_bound_s   = (depth_inc_s == DW'(MAX_DEPTH));
  end

  // Controller: start wins over any step; checks run on the next-state vectors.
  always_comb begin
    fsm_n_s     = fsm_r;
    state_a_n_s = state_a_r;
    state_b_n_s = state_b_r;
    depth_n_s   = depth_r;
    stable_n_s  = stable_r;
    if (start) begin
      fsm_n_s     = RUN;
      state_a_n_s = {WIDTH{1'b0}};
      state_b_n_s = {WIDTH{1'b0}};
      depth_n_s   = {DW{1'b0}};
      stable_n_s  = {SW{1'b0}};
    end else if ((fsm_r == RUN) && step_valid) begin
      state_a_n_s = next_a_s;
      state_b_n_s = next_b_s;
      depth_n_s   = depth_inc_s;
      if (next_a_s[OBS_BIT] != next_b_s[OBS_BIT]) begin
        fsm_n_s = FAIL_S;
      end else if (unchanged_s) begin
        stable_n_s = stable_inc_s;
        if (stable_inc_s == SW'(STABLE)) begin
          fsm_n_s = PASS_S;
        end else if (at_bound_s) begin
          fsm_n_s = BOUND_S;
        end else begin
          fsm_n_s = RUN;
        end
      end else begin
        stable_n_s = {SW{1'b0}};
        if (at_bound_s) begin
          fsm_n_s = BOUND_S;
        end else begin
          fsm_n_s = RUN;
        end
      end
    end else begin
      fsm_n_s = fsm_r;
    end
  end

  // Verdict implied by the upcoming controller state.
  always_comb begin
    verdict_n_s = NONE;
    case (fsm_n_s)
      PASS_S:  verdict_n_s = PASS;
      FAIL_S:  verdict_n_s = FAIL;
      BOUND_S: verdict_n_s = BOUND;
      default: verdict_n_s = NONE;
    endcase
  end

  // State and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_r        <= IDLE;
      state_a_r    <= {WIDTH{1'b0}};
      state_b_r    <= {WIDTH{1'b0}};
      depth_r      <= {DW{1'b0}};
      stable_r     <= {SW{1'b0}};
      verdict_r    <= NONE;
      done_r       <= 1'b0;
      step_ready_r <= 1'b0;
    end else begin
      fsm_r        <= fsm_n_s;
      state_a_r    <= state_a_n_s;
      state_b_r    <= state_b_n_s;
      depth_r      <= depth_n_s;
      stable_r     <= stable_n_s;
      verdict_r    <= verdict_n_s;
      done_r       <= (verdict_n_s != NONE);
      step_ready_r <= (fsm_n_s == RUN);
    end
  end

  assign state_a    = state_a_r;
  assign state_b    = state_b_r;
  assign depth      = depth_r;
  assign done       = done_r;
  assign verdict    = verdict_r;
  assign step_ready = step_ready_r;

endmodule
